// File: rtl/gpio_input_port.sv
// 32-bit GPIO input port with a two-flop synchronizer and word-wide debounce.
// It provides DATA, EDGE (rising-edge latch, write-1-to-clear), MASK and RAW registers and a masked interrupt.
module gpio_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] gpio_in,
    input  logic [1:0]  Addr,
    input  logic        RdEn,
    input  logic        WrEn,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        RdValid,
    output logic        Irq
);

    localparam int unsigned DW = 32;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0]    s1_q, s1_d;
    logic [DW-1:0]    s2_q, s2_d;
    logic [DW-1:0]    cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    data_q, data_d;
    logic [DW-1:0]    edge_q, edge_d;
    logic [DW-1:0]    mask_q, mask_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             irq_q, irq_d;

    // Next-state logic for synchronizer, debounce, register file and read port
    always_comb begin
        s1_d       = gpio_in;
        s2_d       = s1_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        edge_d     = edge_q;
        mask_d     = mask_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = RdEn;
        irq_d      = |(edge_q & mask_q);

        // Any difference restarts the count; a full stable window commits the candidate
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            data_d = cand_q;
        end

        if (WrEn) begin
            case (Addr)
                ADDR_EDGE: edge_d = edge_q & ~WrData;
                ADDR_MASK: mask_d = WrData;
                default:   ;
            endcase
        end
        // Applied after the clear so a simultaneous new rising edge survives
        edge_d = edge_d | (data_d & ~data_q);

        if (RdEn) begin
            case (Addr)
                ADDR_DATA: rd_data_d = data_q;
                ADDR_EDGE: rd_data_d = edge_q;
                ADDR_MASK: rd_data_d = mask_q;
                default:   rd_data_d = s2_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign Irq     = irq_q;

endmodule

// File: tb/tb_gpio_input_port.sv
// Bench for gpio_input_port: directed scenarios followed by random traffic.
// A window-based reference model supplies every expected value.
module tb_gpio_input_port;

    localparam int unsigned D = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] gpio_in;
    logic [1:0]  Addr;
    logic        RdEn;
    logic        WrEn;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        RdValid;
    logic        Irq;

    int checks = 0;
    int errors = 0;

    // Pins sampled at the last D+3 edges; the oldest D+1 form the acceptance window
    logic [31:0] hist[$];
    logic [31:0] m_data, m_edge, m_mask, m_rd_data;
    logic        m_rd_valid, m_irq;
    logic [31:0] rd_val;

    gpio_input_port #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .gpio_in (gpio_in),
        .Addr    (Addr),
        .RdEn    (RdEn),
        .WrEn    (WrEn),
        .WrData  (WrData),
        .RdData  (RdData),
        .RdValid (RdValid),
        .Irq     (Irq)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge, update the model, then compare the visible outputs
    task automatic step();
        logic [31:0] old_data, old_edge, old_mask, v, raw, clr;
        bit          stable;
        @(posedge Clk);
        hist.push_back(gpio_in);
        void'(hist.pop_front());
        if (!Reset) begin
            foreach (hist[i]) hist[i] = '0;
            m_data = '0; m_edge = '0; m_mask = '0;
            m_rd_data = '0; m_rd_valid = 1'b0; m_irq = 1'b0;
        end else begin
            old_data = m_data;
            old_edge = m_edge;
            old_mask = m_mask;
            raw      = hist[D];
            v        = hist[0];
            stable   = 1'b1;
            for (int i = 1; i <= int'(D); i++) if (hist[i] != v) stable = 1'b0;
            m_irq      = |(old_edge & old_mask);
            m_rd_valid = RdEn;
            if (RdEn) begin
                case (Addr)
                    2'd0:    m_rd_data = old_data;
                    2'd1:    m_rd_data = old_edge;
                    2'd2:    m_rd_data = old_mask;
                    default: m_rd_data = raw;
                endcase
            end
            if (stable) m_data = v;
            clr    = (WrEn && Addr == 2'd1) ? WrData : 32'h0;
            m_edge = (old_edge & ~clr) | (m_data & ~old_data);
            if (WrEn && Addr == 2'd2) m_mask = WrData;
        end
        #1;
        check_eq("rd_valid", 32'(RdValid), 32'(m_rd_valid));
        check_eq("rd_data", RdData, m_rd_data);
        check_eq("irq", 32'(Irq), 32'(m_irq));
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] val);
        RdEn = 1'b1;
        Addr = a;
        step();
        RdEn = 1'b0;
        val  = RdData;
    endtask

    initial begin
        for (int i = 0; i < int'(D) + 3; i++) hist.push_back('0);
        m_data = '0; m_edge = '0; m_mask = '0;
        m_rd_data = '0; m_rd_valid = 1'b0; m_irq = 1'b0;
        Reset = 1'b0; gpio_in = '0; Addr = '0; RdEn = 1'b0; WrEn = 1'b0; WrData = '0;

        // Reset state
        step(); step();
        check_eq("rst_rd_data", RdData, 32'h0);
        check_eq("rst_rd_valid", 32'(RdValid), 32'h0);
        check_eq("rst_irq", 32'(Irq), 32'h0);
        Reset = 1'b1;
        repeat (3) step();
        read_reg(2'd0, rd_val);
        check_eq("data_after_rst", rd_val, 32'h0);
        check_eq("rd_valid_pulse_hi", 32'(RdValid), 32'h1);
        step();
        check_eq("rd_valid_pulse_lo", 32'(RdValid), 32'h0);

        // Acceptance latency: pins applied after edge 0 land in DATA on edge D+3
        gpio_in = 32'hA5;
        repeat (D + 2) step();
        RdEn = 1'b1; Addr = 2'd0;
        step();
        check_eq("data_before_accept", RdData, 32'h0);
        step();
        check_eq("data_accepted", RdData, 32'hA5);
        RdEn = 1'b0;
        read_reg(2'd1, rd_val);
        check_eq("edge_after_accept", rd_val, 32'hA5);
        check_eq("irq_unmasked", 32'(Irq), 32'h0);

        // Mask enables interrupt, W1C clears it
        WrEn = 1'b1; Addr = 2'd2; WrData = 32'h1;
        step();
        WrEn = 1'b0;
        step();
        check_eq("irq_after_mask", 32'(Irq), 32'h1);
        WrEn = 1'b1; Addr = 2'd1; WrData = 32'h1;
        step();
        WrEn = 1'b0;
        read_reg(2'd1, rd_val);
        check_eq("edge_after_w1c", rd_val, 32'hA4);
        check_eq("irq_after_w1c", 32'(Irq), 32'h0);

        // Short glitch on bit 3 must be rejected but visible in RAW
        gpio_in = 32'hAD;
        step(); step();
        gpio_in = 32'hA5;
        read_reg(2'd3, rd_val);
        check_eq("raw_glitch_bit3", rd_val & 32'h8, 32'h8);
        repeat (12) step();
        read_reg(2'd0, rd_val);
        check_eq("data_after_glitch", rd_val, 32'hA5);
        read_reg(2'd1, rd_val);
        check_eq("edge_after_glitch", rd_val, 32'hA4);
        check_eq("irq_after_glitch", 32'(Irq), 32'h0);

        // Rising edge on bit 5 coinciding with its W1C keeps the bit set
        gpio_in = 32'h85;
        WrEn = 1'b1; Addr = 2'd1; WrData = 32'h20;
        step();
        WrEn = 1'b0;
        repeat (11) step();
        read_reg(2'd1, rd_val);
        check_eq("edge_bit5_cleared", rd_val, 32'h84);
        gpio_in = 32'hA5;
        repeat (D + 2) step();
        WrEn = 1'b1; Addr = 2'd1; WrData = 32'h20;
        step();
        WrEn = 1'b0;
        read_reg(2'd1, rd_val);
        check_eq("edge_set_wins", rd_val, 32'hA4);
        read_reg(2'd0, rd_val);
        check_eq("data_bit5_back", rd_val, 32'hA5);

        // Reset mid-debounce with a read in the same cycle
        gpio_in = 32'hF0;
        repeat (3) step();
        Reset = 1'b0; RdEn = 1'b1; Addr = 2'd1;
        step();
        check_eq("rst_drops_read", 32'(RdValid), 32'h0);
        check_eq("rst_clears_rd_data", RdData, 32'h0);
        Reset = 1'b1; RdEn = 1'b0;
        step();
        check_eq("no_late_rd_valid", 32'(RdValid), 32'h0);
        repeat (D + 1) step();
        RdEn = 1'b1; Addr = 2'd0;
        step();
        check_eq("reaccept_pending", RdData, 32'h0);
        step();
        check_eq("reaccept_done", RdData, 32'hF0);
        RdEn = 1'b0;
        read_reg(2'd1, rd_val);
        check_eq("edge_after_reaccept", rd_val, 32'hF0);
        read_reg(2'd2, rd_val);
        check_eq("mask_after_rst", rd_val, 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) gpio_in = $urandom;
            else if (r < 14) gpio_in = gpio_in ^ (32'd1 << $urandom_range(0, 31));
            RdEn   = ($urandom_range(0, 2) == 0);
            WrEn   = ($urandom_range(0, 3) == 0);
            Addr   = 2'($urandom_range(0, 3));
            WrData = $urandom;
            Reset  = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
